// File: rtl/dma_wr_frame_ctrl.sv
// FIFO-to-DMA burst writer: drains fixed bursts into a ring of frame buffers,
// rotates buffers per frame (skipping a locked one) and flags short/long bursts.
module dma_wr_frame_ctrl #(
  parameter int          DATA_W           = 64,
  parameter int          CNT_W            = 10,
  parameter int          BURST_LEN        = 418,
  parameter int          BURSTS_PER_FRAME = 258,
  parameter int          NUM_BUFS         = 2,
  parameter logic [31:0] BUF_BASE         = 32'h3500_0000,
  parameter logic [31:0] BUF_STRIDE       = 32'h0100_0000
) (
  input  logic              ui_clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              lock_en,
  input  logic [2:0]        lock_idx,
  input  logic [CNT_W-1:0]  fifo_count,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_data,
  output logic [31:0]       dma_waddr,
  output logic              dma_wareq,
  output logic [15:0]       dma_wsize,
  input  logic              dma_wbusy,
  input  logic              dma_wvalid,
  output logic [DATA_W-1:0] dma_wdata,
  output logic              dma_wready,
  output logic [2:0]        wr_buf_idx,
  output logic [2:0]        done_buf_idx,
  output logic              frame_done,
  output logic              beat_err
);

  localparam int BC_W =
    (BURSTS_PER_FRAME > 1) ? $clog2(BURSTS_PER_FRAME) : 1;
  localparam logic [31:0] BURST_BYTES =
    32'(BURST_LEN * (DATA_W / 8));
  localparam logic [31:0] BLEN32 = 32'(BURST_LEN);
  localparam logic [15:0] BLEN = 16'(BURST_LEN);
  localparam logic [BC_W-1:0] LAST_BURST =
    BC_W'(BURSTS_PER_FRAME - 1);
  localparam logic [2:0] LAST_BUF = 3'(NUM_BUFS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_REQ, S_BUSY, S_ADV
  } state_t;

  state_t          state_q, state_d;
  logic            wareq_q, wareq_d;
  logic            frame_done_q, frame_done_d;
  logic            beat_err_q, beat_err_d;
  logic [2:0]      wr_buf_q, wr_buf_d;
  logic [2:0]      done_buf_q, done_buf_d;
  logic [BC_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [15:0]     beat_cnt_q, beat_cnt_d;
  logic [31:0]     waddr_q, waddr_d;

  logic [2:0]  inc1, inc2, nxt_buf;
  logic [15:0] beat_inc;
  logic [31:0] fifo_cnt32;

  always_comb begin
    inc1 = (wr_buf_q == LAST_BUF) ? 3'd0 : wr_buf_q + 3'd1;
    inc2 = (inc1 == LAST_BUF) ? 3'd0 : inc1 + 3'd1;
    // With only two buffers the writer may overwrite a locked one
    nxt_buf = (NUM_BUFS >= 3 && lock_en && inc1 == lock_idx)
              ? inc2 : inc1;
    beat_inc = (dma_wvalid && beat_cnt_q != 16'hFFFF)
               ? beat_cnt_q + 16'd1 : beat_cnt_q;
    fifo_cnt32 = 32'(fifo_count);
  end

  always_comb begin
    state_d      = state_q;
    wareq_d      = wareq_q;
    frame_done_d = 1'b0;
    beat_err_d   = beat_err_q;
    wr_buf_d     = wr_buf_q;
    done_buf_d   = done_buf_q;
    burst_cnt_d  = burst_cnt_q;
    beat_cnt_d   = beat_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_ARM;
      end
      S_ARM: begin
        if (!enable) begin
          state_d     = S_IDLE;
          burst_cnt_d = '0;
        end else if (fifo_cnt32 >= BLEN32 && !dma_wbusy) begin
          state_d = S_REQ;
          wareq_d = 1'b1;
        end
      end
      S_REQ: begin
        if (dma_wbusy) begin
          wareq_d = 1'b0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        beat_cnt_d = beat_inc;
        if (!dma_wbusy) begin
          state_d = S_ADV;
          if (beat_inc != BLEN) beat_err_d = 1'b1;
        end
      end
      S_ADV: begin
        beat_cnt_d = '0;
        if (burst_cnt_q == LAST_BURST) begin
          burst_cnt_d  = '0;
          frame_done_d = 1'b1;
          done_buf_d   = wr_buf_q;
          wr_buf_d     = nxt_buf;
        end else begin
          burst_cnt_d = burst_cnt_q + 1'b1;
        end
        // Stopping drops the partial frame but keeps the buffer
        if (enable) begin
          state_d = S_ARM;
        end else begin
          state_d     = S_IDLE;
          burst_cnt_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    waddr_d = BUF_BASE + 32'(wr_buf_d) * BUF_STRIDE
              + 32'(burst_cnt_d) * BURST_BYTES;
  end

  always_ff @(posedge ui_clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wareq_q      <= 1'b0;
      frame_done_q <= 1'b0;
      beat_err_q   <= 1'b0;
      wr_buf_q     <= 3'd0;
      done_buf_q   <= LAST_BUF;
      burst_cnt_q  <= '0;
      beat_cnt_q   <= '0;
      waddr_q      <= BUF_BASE;
    end else begin
      state_q      <= state_d;
      wareq_q      <= wareq_d;
      frame_done_q <= frame_done_d;
      beat_err_q   <= beat_err_d;
      wr_buf_q     <= wr_buf_d;
      done_buf_q   <= done_buf_d;
      burst_cnt_q  <= burst_cnt_d;
      beat_cnt_q   <= beat_cnt_d;
      waddr_q      <= waddr_d;
    end
  end

  assign fifo_rd_en   = (state_q == S_BUSY) && dma_wvalid;
  assign dma_wdata    = fifo_data;
  assign dma_wready   = 1'b1;
  assign dma_wsize    = BLEN;
  assign dma_wareq    = wareq_q;
  assign dma_waddr    = waddr_q;
  assign wr_buf_idx   = wr_buf_q;
  assign done_buf_idx = done_buf_q;
  assign frame_done   = frame_done_q;
  assign beat_err     = beat_err_q;

endmodule

// File: tb/tb_dma_wr_frame_ctrl.sv
// Directed bench for dma_wr_frame_ctrl: 4-beat bursts, 3 bursts/frame,
// 3 buffers 0x1000 apart, with a small inline DMA responder.
module tb_dma_wr_frame_ctrl;

  logic        ui_clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        lock_en;
  logic [2:0]  lock_idx;
  logic [9:0]  fifo_count;
  logic        fifo_rd_en;
  logic [63:0] fifo_data;
  logic [31:0] dma_waddr;
  logic        dma_wareq;
  logic [15:0] dma_wsize;
  logic        dma_wbusy;
  logic        dma_wvalid;
  logic [63:0] dma_wdata;
  logic        dma_wready;
  logic [2:0]  wr_buf_idx;
  logic [2:0]  done_buf_idx;
  logic        frame_done;
  logic        beat_err;

  int errors = 0;
  int checks = 0;

  always #5 ui_clk = ~ui_clk;

  dma_wr_frame_ctrl #(
    .DATA_W(64), .CNT_W(10), .BURST_LEN(4),
    .BURSTS_PER_FRAME(3), .NUM_BUFS(3),
    .BUF_BASE(32'h3500_0000), .BUF_STRIDE(32'h0000_1000)
  ) dut (
    .ui_clk(ui_clk), .rst(rst), .enable(enable),
    .lock_en(lock_en), .lock_idx(lock_idx),
    .fifo_count(fifo_count), .fifo_rd_en(fifo_rd_en),
    .fifo_data(fifo_data), .dma_waddr(dma_waddr),
    .dma_wareq(dma_wareq), .dma_wsize(dma_wsize),
    .dma_wbusy(dma_wbusy), .dma_wvalid(dma_wvalid),
    .dma_wdata(dma_wdata), .dma_wready(dma_wready),
    .wr_buf_idx(wr_buf_idx), .done_buf_idx(done_buf_idx),
    .frame_done(frame_done), .beat_err(beat_err)
  );

  task automatic tick;
    @(posedge ui_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Wait for a request, grant it, deliver nb beats, end the burst.
  // Returns one cycle after ADV, i.e. with frame_done visible.
  task automatic serve(input int nb, input bit drop_en,
                       output logic [31:0] addr);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (dma_wareq === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    chk("wareq_seen", 64'(seen), 64'd1);
    addr = dma_waddr;
    dma_wbusy = 1'b1;
    tick();
    chk("wareq_drop", 64'(dma_wareq), 64'd0);
    if (drop_en) enable = 1'b0;
    for (int i = 0; i < nb; i++) begin
      dma_wvalid = 1'b1;
      if (i == 0) begin
        #1;
        chk("rd_en_beat", 64'(fifo_rd_en), 64'd1);
      end
      tick();
    end
    dma_wvalid = 1'b0;
    dma_wbusy  = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    logic [31:0] a;
    bit got;
    rst        = 1'b1;
    enable     = 1'b0;
    lock_en    = 1'b0;
    lock_idx   = 3'd0;
    fifo_count = 10'd0;
    fifo_data  = 64'hDEAD_BEEF_0123_4567;
    dma_wbusy  = 1'b0;
    dma_wvalid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    chk("rst_wareq", 64'(dma_wareq), 64'd0);
    chk("rst_rd_en", 64'(fifo_rd_en), 64'd0);
    chk("rst_fdone", 64'(frame_done), 64'd0);
    chk("rst_berr", 64'(beat_err), 64'd0);
    chk("rst_wrbuf", 64'(wr_buf_idx), 64'd0);
    chk("rst_donebuf", 64'(done_buf_idx), 64'd2);
    chk("rst_addr", 64'(dma_waddr), 64'h3500_0000);
    chk("wsize", 64'(dma_wsize), 64'd4);
    chk("wready", 64'(dma_wready), 64'd1);
    chk("wdata", dma_wdata, 64'hDEAD_BEEF_0123_4567);

    // T1: one full frame into buffer 0
    fifo_count = 10'd4;
    enable = 1'b1;
    serve(4, 1'b0, a);
    chk("t1_addr0", 64'(a), 64'h3500_0000);
    chk("t1_fd_mid", 64'(frame_done), 64'd0);
    serve(4, 1'b0, a);
    chk("t1_addr1", 64'(a), 64'h3500_0020);
    serve(4, 1'b0, a);
    chk("t1_addr2", 64'(a), 64'h3500_0040);
    chk("t1_fdone", 64'(frame_done), 64'd1);
    chk("t1_wrbuf", 64'(wr_buf_idx), 64'd1);
    chk("t1_donebuf", 64'(done_buf_idx), 64'd0);
    chk("t1_berr", 64'(beat_err), 64'd0);

    // T3: not enough data; stray beats outside BUSY
    fifo_count = 10'd3;
    dma_wvalid = 1'b1;
    tick();
    chk("t1_fd_pulse", 64'(frame_done), 64'd0);
    chk("t3_stray_rd", 64'(fifo_rd_en), 64'd0);
    dma_wvalid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (dma_wareq !== 1'b0) got = 1'b1;
      tick();
    end
    chk("t3_no_req", 64'(got), 64'd0);
    fifo_count = 10'd4;
    got = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (dma_wareq === 1'b1) got = 1'b1;
    end
    chk("t3_req", 64'(got), 64'd1);
    chk("t3_addr", 64'(dma_waddr), 64'h3500_1000);

    // T4: short burst flags beat_err, writer continues
    serve(3, 1'b0, a);
    chk("t4_addr", 64'(a), 64'h3500_1000);
    chk("t4_berr", 64'(beat_err), 64'd1);

    // T5: stop during burst 1, restart at burst 0 same buffer
    serve(4, 1'b1, a);
    chk("t5_addr", 64'(a), 64'h3500_1020);
    got = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (dma_wareq !== 1'b0) got = 1'b1;
      tick();
    end
    chk("t5_idle", 64'(got), 64'd0);
    chk("t5_addr_rst", 64'(dma_waddr), 64'h3500_1000);
    chk("t5_wrbuf", 64'(wr_buf_idx), 64'd1);
    enable = 1'b1;
    serve(4, 1'b0, a);
    chk("t5_restart", 64'(a), 64'h3500_1000);
    chk("t5_berr_sticky", 64'(beat_err), 64'd1);

    // T6: async reset while a request is pending
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (dma_wareq === 1'b1) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    chk("t6_req", 64'(got), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_wareq", 64'(dma_wareq), 64'd0);
    chk("t6_wrbuf", 64'(wr_buf_idx), 64'd0);
    chk("t6_donebuf", 64'(done_buf_idx), 64'd2);
    chk("t6_berr", 64'(beat_err), 64'd0);
    chk("t6_addr", 64'(dma_waddr), 64'h3500_0000);
    #2 rst = 1'b0;
    tick();

    // T2: buffer 1 locked, frame 0 rotates to buffer 2
    lock_en  = 1'b1;
    lock_idx = 3'd1;
    serve(4, 1'b0, a);
    chk("t2_addr0", 64'(a), 64'h3500_0000);
    serve(4, 1'b0, a);
    chk("t2_addr1", 64'(a), 64'h3500_0020);
    serve(4, 1'b0, a);
    chk("t2_addr2", 64'(a), 64'h3500_0040);
    chk("t2_fdone", 64'(frame_done), 64'd1);
    chk("t2_wrbuf", 64'(wr_buf_idx), 64'd2);
    chk("t2_donebuf", 64'(done_buf_idx), 64'd0);
    serve(4, 1'b0, a);
    chk("t2_newaddr", 64'(a), 64'h3500_2000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
